// File: rtl/fp_issue_buffer_if.sv
// Stream interface bundling operand intake, FP unit hookup and result output
// of fp_issue_buffer.
interface fp_issue_buffer_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] fpu_a;
    logic [WIDTH-1:0] fpu_b;
    logic [WIDTH-1:0] fpu_q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready, fpu_q,
        input  in_ready, out_valid, out_data, out_tag, fpu_a, fpu_b
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready, fpu_q,
        output in_ready, out_valid, out_data, out_tag, fpu_a, fpu_b
    );
endinterface

// File: rtl/fp_issue_buffer.sv
// Issue/collect wrapper around a fixed-latency FP unit: tracks valid+tag beside
// the unit pipeline and buffers results in a credit-protected FIFO.
module fp_issue_buffer #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 8,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input logic               clk,
    input logic               areset,
    fp_issue_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LATENCY-1:0] vld_p;
    logic [TAG_W-1:0]   tag_p [LATENCY];
    logic [WIDTH-1:0]   mem_data [DEPTH];
    logic [TAG_W-1:0]   mem_tag  [DEPTH];

    logic fire_in;
    logic fire_out;
    logic capture;

    assign bus.in_ready  = (credits != '0);
    assign bus.out_valid = (count != '0);
    assign bus.fpu_a     = bus.in_a;
    assign bus.fpu_b     = bus.in_b;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_tag   = mem_tag[rd_ptr];

    assign fire_in  = bus.in_valid & bus.in_ready;
    assign fire_out = bus.out_valid & bus.out_ready;
    assign capture  = vld_p[LATENCY-1];

    // Control: tracker valid bits, FIFO pointers/occupancy, admission credits
    always_ff @(posedge clk) begin
        if (areset) begin
            credits <= CNT_W'(DEPTH);
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            vld_p   <= '0;
        end else begin
            vld_p[0] <= fire_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fire_out) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fire_in, fire_out})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
            case ({capture, fire_out})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data: tag pipeline and result storage carry no reset; validity is in vld_p/count
    always_ff @(posedge clk) begin
        tag_p[0] <= bus.in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
        if (capture) begin
            mem_data[wr_ptr] <= bus.fpu_q;
            mem_tag[wr_ptr]  <= tag_p[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_fp_issue_buffer.sv
// Scoreboard bench for fp_issue_buffer: a LATENCY=1 and a LATENCY=3 instance,
// each attached to a behavioural FP-max unit.
module tb_fp_issue_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    fp_issue_buffer_if #(.WIDTH(32), .TAG_W(8)) bus1 ();
    fp_issue_buffer_if #(.WIDTH(32), .TAG_W(8)) bus3 ();

    fp_issue_buffer #(.WIDTH(32), .TAG_W(8), .LATENCY(1), .DEPTH(DEPTH)) u1 (
        .clk(clk), .areset(areset), .bus(bus1)
    );
    fp_issue_buffer #(.WIDTH(32), .TAG_W(8), .LATENCY(3), .DEPTH(DEPTH)) u3 (
        .clk(clk), .areset(areset), .bus(bus3)
    );

    function automatic logic [31:0] fmax(logic [31:0] x, logic [31:0] y);
        if (x[31] != y[31]) return x[31] ? y : x;
        if (!x[31]) return (x > y) ? x : y;
        return (x < y) ? x : y;
    endfunction

    // Unit models are never reset, so stale results stay in their pipelines
    logic [31:0] q1;
    logic [31:0] s3 [3];
    always_ff @(posedge clk) begin
        q1    <= fmax(bus1.fpu_a, bus1.fpu_b);
        s3[0] <= fmax(bus3.fpu_a, bus3.fpu_b);
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign bus1.fpu_q = q1;
    assign bus3.fpu_q = s3[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [39:0] sb1 [$];
    logic [39:0] sb3 [$];

    logic        iv1, or1, iv3, or3;
    logic [31:0] a1, bv1, a3, bv3;
    logic [7:0]  t1, t3;
    logic        f_in1, f_out1, rdy1, ov1;
    logic        f_in3, f_out3, rdy3, ov3;
    logic [31:0] last_data1;
    int          cyc = 0;
    int          last_pop1 = -1;
    int          acc_cyc = -1;
    bit          mode6 = 1'b0;

    task automatic tick();
        logic [39:0] e;
        bus1.in_valid = iv1; bus1.in_a = a1; bus1.in_b = bv1; bus1.in_tag = t1; bus1.out_ready = or1;
        bus3.in_valid = iv3; bus3.in_a = a3; bus3.in_b = bv3; bus3.in_tag = t3; bus3.out_ready = or3;
        #1;
        rdy1 = bus1.in_ready; ov1 = bus1.out_valid;
        rdy3 = bus3.in_ready; ov3 = bus3.out_valid;
        f_in1 = iv1 && rdy1; f_out1 = ov1 && or1;
        f_in3 = iv3 && rdy3; f_out3 = ov3 && or3;
        if (mode6) chk("t6_ready_vs_credits", rdy3, (sb3.size() != DEPTH));
        if (f_out1) begin
            if (sb1.size() == 0) chk("u1_spurious_out", 1, 0);
            else begin
                e = sb1.pop_front();
                chk("u1_data", bus1.out_data, e[39:8]);
                chk("u1_tag", bus1.out_tag, e[7:0]);
                last_data1 = bus1.out_data;
            end
            last_pop1 = cyc;
        end
        if (f_out3) begin
            if (sb3.size() == 0) chk("u3_spurious_out", 1, 0);
            else begin
                e = sb3.pop_front();
                chk("u3_data", bus3.out_data, e[39:8]);
                chk("u3_tag", bus3.out_tag, e[7:0]);
            end
        end
        if (f_in1) sb1.push_back({fmax(a1, bv1), t1});
        if (f_in3) sb3.push_back({fmax(a3, bv3), t3});
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int acc, drops, first, cnt, p0;
        iv1 = 0; or1 = 0; a1 = 0; bv1 = 0; t1 = 0;
        iv3 = 0; or3 = 0; a3 = 0; bv3 = 0; t3 = 0;
        @(negedge clk);
        tick(); tick();
        areset = 1'b0;
        tick();
        chk("rst_out_valid1", ov1, 0);
        chk("rst_in_ready1", rdy1, 1);
        chk("rst_out_valid3", ov3, 0);
        chk("rst_in_ready3", rdy3, 1);

        // Test 1: single op
        iv1 = 1; a1 = 32'h3F800000; bv1 = 32'h40000000; t1 = 8'h05; or1 = 1;
        tick();
        if (f_in1) acc_cyc = cyc - 1;
        chk("t1_accept", f_in1, 1);
        iv1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_in_ready", rdy1, 1);
        end
        chk("t1_latency", last_pop1 - acc_cyc, 2);
        chk("t1_q", last_data1, 32'h40000000);
        chk("t1_sb_empty", sb1.size(), 0);

        // Test 2: 100 back-to-back
        drops = 0; first = -1; cnt = 0;
        for (int i = 0; i < 100; i++) begin
            iv1 = 1; a1 = $urandom; bv1 = $urandom; t1 = 8'(i); or1 = 1;
            tick();
            if (!rdy1) drops++;
            if (f_out1) begin cnt++; if (first < 0) first = last_pop1; end
        end
        iv1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (f_out1) begin cnt++; if (first < 0) first = last_pop1; end
        end
        chk("t2_ready_drops", drops, 0);
        chk("t2_results", cnt, 100);
        chk("t2_span", last_pop1 - first, 99);

        // Test 3: fill with out_ready low, then drain
        acc = 0; or1 = 0;
        for (int i = 0; i < 8; i++) begin
            iv1 = 1; a1 = $urandom; bv1 = $urandom; t1 = 8'(8'h40 + i);
            tick();
            if (f_in1) acc++;
        end
        chk("t3_accepted", acc, DEPTH);
        chk("t3_ready_low", rdy1, 0);
        iv1 = 0; or1 = 1;
        tick();
        chk("t3_first_drain", f_out1, 1);
        tick();
        chk("t3_ready_after_drain", rdy1, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_sb_empty", sb1.size(), 0);

        // Test 4: drain and request in the same cycle at zero credits
        or1 = 0;
        for (int i = 0; i < 6; i++) begin
            iv1 = 1; a1 = $urandom; bv1 = $urandom; t1 = 8'(8'h80 + i);
            tick();
        end
        iv1 = 1; or1 = 1; t1 = 8'h90; a1 = $urandom; bv1 = $urandom;
        tick();
        chk("t4_ready_zero", rdy1, 0);
        chk("t4_drain", f_out1, 1);
        iv1 = 1; or1 = 0; t1 = 8'h91; a1 = $urandom; bv1 = $urandom;
        tick();
        chk("t4_ready_one", rdy1, 1);
        chk("t4_accept", f_in1, 1);
        tick();
        chk("t4_ready_zero_again", rdy1, 0);
        iv1 = 0; or1 = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("t4_sb_empty", sb1.size(), 0);

        // Test 5: reset with work in flight and buffered
        or1 = 0; or3 = 0;
        for (int i = 0; i < 4; i++) begin
            iv1 = 1; a1 = $urandom; bv1 = $urandom; t1 = 8'(8'hA0 + i);
            iv3 = 1; a3 = $urandom; bv3 = $urandom; t3 = 8'(8'hB0 + i);
            tick();
        end
        iv1 = 0; iv3 = 0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        sb1.delete(); sb3.delete();
        or1 = 1; or3 = 1;
        tick();
        chk("t5_out_valid1", ov1, 0);
        chk("t5_in_ready1", rdy1, 1);
        chk("t5_out_valid3", ov3, 0);
        chk("t5_in_ready3", rdy3, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov1 || ov3) cnt++;
        end
        chk("t5_no_stale", cnt, 0);

        // Test 6: random traffic on the LATENCY=3 instance
        or1 = 0; mode6 = 1'b1; p0 = 0;
        for (int i = 0; i < 10000; i++) begin
            iv3 = ($urandom_range(0, 9) < 7); a3 = $urandom; bv3 = $urandom; t3 = 8'(i);
            or3 = ($urandom_range(0, 9) < 6);
            tick();
            if (f_in3) p0++;
        end
        iv3 = 0; or3 = 1;
        for (int i = 0; i < 20; i++) tick();
        mode6 = 1'b0;
        chk("t6_sb_empty", sb3.size(), 0);
        chk("t6_some_traffic", (p0 > 1000), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
